// File: rtl/i2s_voice_scheduler.sv
// Per-frame voice poller/mixer feeding the I2S transmitter: polls enabled voices once
// per 1024-cycle frame, sums their samples, scales/saturates, and publishes at frame end.
module i2s_voice_scheduler #(
  parameter int VW      = 3,
  parameter int TIMEOUT = 15,
  parameter int SHIFT   = 2,
  localparam int NVOICE = 2**VW
) (
  input  logic              clk48m,
  input  logic              rst,
  input  logic [NVOICE-1:0] voice_en,
  output logic              req_valid,
  output logic [VW-1:0]     req_voice,
  input  logic              req_ack,
  input  logic [15:0]       req_data,
  output logic [15:0]       signal,
  output logic              frame_tick,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        miss_count
);
  localparam int ACCW = 16 + VW;
  localparam logic [VW-1:0] LAST  = '1;
  localparam logic [7:0]    WLAST = 8'(TIMEOUT - 1);
  localparam logic signed [ACCW-1:0] MAXV = ACCW'(32767);
  localparam logic signed [ACCW-1:0] MINV = ACCW'(-32768);

  typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_t;

  state_t                  state, state_n;
  logic [9:0]              fcnt;
  logic [NVOICE-1:0]       en_q;
  logic [VW-1:0]           idx;
  logic [7:0]              wcnt;
  logic signed [ACCW-1:0]  acc;
  logic [15:0]             pending;
  logic signed [ACCW-1:0]  shifted;
  logic [15:0]             sat16;
  logic start, issue, take, tmo, adv, fin;

  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > MAXV)      sat16 = 16'h7FFF;
    else if (shifted < MINV) sat16 = 16'h8000;
    else                     sat16 = shifted[15:0];
  end

  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start = 1'b0; issue = 1'b0; take = 1'b0; tmo = 1'b0; adv = 1'b0; fin = 1'b0;
    case (state)
      IDLE: if (fcnt == 10'd0) begin
        start   = 1'b1;
        state_n = SCAN;
      end
      SCAN: begin
        if (en_q[idx]) begin
          issue   = 1'b1;
          state_n = REQ;
        end else if (idx == LAST) state_n = DONE;
        else adv = 1'b1;
      end
      REQ: begin
        // an ack on the final wait cycle wins over the timeout
        take = req_ack;
        tmo  = !req_ack && (wcnt == WLAST);
        if (take || tmo) begin
          if (idx == LAST) state_n = DONE;
          else begin
            adv     = 1'b1;
            state_n = SCAN;
          end
        end
      end
      DONE: begin
        fin     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      fcnt        <= '0;
      en_q        <= '0;
      idx         <= '0;
      wcnt        <= '0;
      acc         <= '0;
      pending     <= '0;
      signal      <= '0;
      req_valid   <= 1'b0;
      req_voice   <= '0;
      frame_tick  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      miss_count  <= '0;
    end else begin
      fcnt        <= fcnt + 10'd1;
      frame_tick  <= (fcnt == 10'd1023);
      if (fcnt == 10'd1023) signal <= pending;
      timeout_err <= tmo;
      if (tmo && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
      if (start) begin
        en_q <= voice_en;
        acc  <= '0;
        idx  <= '0;
        busy <= 1'b1;
      end
      if (issue) begin
        req_valid <= 1'b1;
        req_voice <= idx;
        wcnt      <= '0;
      end
      if (state == REQ) wcnt <= wcnt + 8'd1;
      if (take || tmo) req_valid <= 1'b0;
      if (take) acc <= acc + {{VW{req_data[15]}}, req_data};
      if (adv) idx <= idx + 1'b1;
      if (fin) begin
        pending <= sat16;
        busy    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_voice_scheduler.sv
// Randomized bench for i2s_voice_scheduler: a per-frame timeline model derived from
// voice latencies predicts every output cycle; literal tables pin key frame results.
module tb_i2s_voice_scheduler;
  localparam int NV = 8;
  localparam int TO = 15;
  localparam int NF = 54;

  logic        clk48m = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  voice_en;
  logic        req_valid;
  logic [2:0]  req_voice;
  logic        req_ack;
  logic [15:0] req_data;
  logic [15:0] signal;
  logic        frame_tick, busy, timeout_err;
  logic [7:0]  miss_count;

  always #10 clk48m = ~clk48m;

  i2s_voice_scheduler #(.VW(3), .TIMEOUT(TO), .SHIFT(2)) dut (
    .clk48m(clk48m), .rst(rst), .voice_en(voice_en), .req_valid(req_valid),
    .req_voice(req_voice), .req_ack(req_ack), .req_data(req_data), .signal(signal),
    .frame_tick(frame_tick), .busy(busy), .timeout_err(timeout_err), .miss_count(miss_count)
  );

  int checks = 0;
  int failures = 0;
  int pos;
  bit post = 1'b0;
  int lat[NV];
  logic [15:0] dat[NV];
  int lit[8] = '{900, 32767, -32768, 16383, 70, 0, 8, 1};

  always @(posedge clk48m or posedge rst)
    if (rst) pos <= 0;
    else     pos <= pos + 1;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, pos);
    end
  endtask

  function automatic logic [7:0] cfg_en(input int k);
    if (k == 5) return 8'h00;
    if (k == 7) return 8'h01;
    if (k >= 8 && k <= 19) return 8'($urandom);
    return 8'hFF;
  endfunction

  task automatic cfg_ld(input int k);
    for (int i = 0; i < NV; i++) begin
      if (k == 0)              begin lat[i] = 2; dat[i] = 16'(100 * (i + 1)); end
      else if (k == 1)         begin lat[i] = $urandom_range(0, 3); dat[i] = 16'h7FFF; end
      else if (k == 2)         begin lat[i] = $urandom_range(0, 3); dat[i] = 16'h8000; end
      else if (k == 3)         begin lat[i] = $urandom_range(0, 3); dat[i] = (i < 2) ? 16'h7FFF : 16'h0000; end
      else if (k == 4)         begin lat[i] = (i == 3) ? 255 : $urandom_range(0, 4); dat[i] = 16'd40; end
      else if (k <= 7)         begin lat[i] = 0; dat[i] = 16'd4; end
      else if (k <= 19)        begin lat[i] = $urandom_range(0, 17); dat[i] = 16'($urandom); end
      else if (k <= 52)        begin lat[i] = 255; dat[i] = 16'($urandom); end
      else                     begin lat[i] = 1; dat[i] = 16'd1000; end
    end
  endtask

  // voice responder: acks lat[v] cycles after the request rises; noise acks while idle
  initial begin : responder
    bit prv;
    int rc;
    prv = 1'b0;
    rc = 0;
    forever begin
      @(negedge clk48m);
      if (req_valid === 1'b1) begin
        rc = prv ? rc + 1 : 0;
        req_ack  = (rc == lat[req_voice]);
        req_data = req_ack ? dat[req_voice] : 16'($urandom);
      end else begin
        req_ack  = ($urandom_range(0, 3) == 0);
        req_data = 16'($urandom);
      end
      prv = (req_valid === 1'b1);
    end
  end

  // frame timeline model: voice j is scanned one cycle, then held for its response time
  bit erv[1024], ebusy[1024], eto[1024];
  int evo[1024];
  int pend, esig, emiss, rvc;

  task automatic build_frame();
    int c, d, sum, s;
    logic [7:0] en;
    for (int t = 0; t < 1024; t++) begin erv[t] = 0; ebusy[t] = 0; eto[t] = 0; evo[t] = 0; end
    en = voice_en;
    c = 1;
    sum = 0;
    for (int j = 0; j < NV; j++) begin
      if (en[j]) begin
        d = (lat[j] < TO) ? lat[j] + 1 : TO;
        for (int t = c + 1; t <= c + d; t++) begin erv[t] = 1; evo[t] = j; end
        if (lat[j] >= TO) eto[c + 1 + d] = 1;
        else sum += int'($signed(dat[j]));
        c += 1 + d;
      end else c += 1;
    end
    for (int t = 1; t <= c; t++) ebusy[t] = 1;
    s = sum >>> 2;
    pend = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
  endtask

  initial begin : model
    int ph, f;
    pend = 0; esig = 0; emiss = 0; rvc = 0;
    forever begin
      @(negedge clk48m);
      if (rst) begin
        pend = 0; esig = 0; emiss = 0;
      end else begin
        ph = pos % 1024;
        f  = pos / 1024;
        if (ph == 0) begin
          esig = pend;
          build_frame();
          rvc = 0;
        end
        if (eto[ph]) emiss = (emiss < 255) ? emiss + 1 : 255;
        chk("req_valid", req_valid, erv[ph]);
        if (erv[ph]) chk("req_voice", req_voice, evo[ph]);
        chk("busy", busy, ebusy[ph]);
        chk("timeout_err", timeout_err, eto[ph]);
        chk("miss_count", miss_count, emiss);
        chk("signal", $signed(signal), esig);
        chk("frame_tick", frame_tick, (ph == 0 && pos != 0));
        if (req_valid === 1'b1 && (f != 4 || req_voice == 3'd3)) rvc++;
        if (!post) begin
          if (ph == 0 && f >= 1 && f <= 8) begin
            chk("lit_signal", $signed(signal), lit[f-1]);
            chk("lit_model", esig, lit[f-1]);
          end
          if (ph == 1023 && f == 0) chk("rv_cycles_f0", rvc, 24);
          if (ph == 1023 && f == 4) chk("rv_cycles_v3", rvc, TO);
          if (ph == 1023 && f == 5) chk("rv_cycles_empty", rvc, 0);
          if (pos == 5 * 1024)  chk("lit_miss1", miss_count, 1);
          if (pos == 53 * 1024) chk("lit_miss255", miss_count, 255);
          if (pos == 54 * 1024) chk("lit_sig2000", $signed(signal), 2000);
        end else begin
          if (pos == 1) chk("post_rv_f1", req_valid, 0);
          if (pos == 2) chk("post_rv_f2", req_valid, 1);
          if (pos == 1024) chk("post_sig", $signed(signal), 2000);
        end
      end
    end
  end

  task automatic run_until(input int last, input int kbase);
    while (pos < last) begin
      @(negedge clk48m);
      #1;
      if (pos % 1024 == 100) voice_en = cfg_en(kbase + pos / 1024 + 1);
      if (pos % 1024 == 600) cfg_ld(kbase + pos / 1024 + 1);
    end
  endtask

  initial begin : main
    int n;
    voice_en = cfg_en(0);
    cfg_ld(0);
    req_ack = 1'b0;
    req_data = '0;
    repeat (3) @(posedge clk48m);
    #2 rst = 1'b0;
    run_until(NF * 1024 + 1, 0);
    n = 0;
    while (req_valid !== 1'b1 && n < 300) begin
      @(negedge clk48m);
      n++;
    end
    chk("req_seen_before_reset", req_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_signal", $signed(signal), 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk48m);
    post = 1'b1;
    #2 rst = 1'b0;
    run_until(2 * 1024 + 1, 60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
